csr_counter_bank: RTL
=====================

Name: csr_counter_bank

Overview:
- Parametrised machine counter block: mcycle, minstret and NUM_HPM hardware performance counters, each COUNTER_WIDTH bits wide.
- Adds mcountinhibit, per-counter event select, multi-retire increment, and RW/RS/RC CSR access using the pipeline's existing CSROp encoding.
- Sits beside the CSR file in execute. The CSR file forwards counter addresses here and muxes csrReadData into oldCSRValue.

Parameters:
COUNTER_WIDTH, 64, counter width in bits; legal range 33..64.
NUM_HPM, 4, number of mhpmcounter3.. counters; legal range 0..29.
NUM_EVENTS, 8, width of the hpmEvent input vector.
MAX_RETIRE, 1, maximum instructions retired per cycle.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
csrValid  input  1  a CSR access is presented this cycle
csrAddr  input  12  CSR address
csrOp  input  2  CSR operation: 00 none, 01 RW, 10 RS, 11 RC
csrWriteIntent  input  1  0 suppresses the write (RS/RC with rs1 = x0)
csrWriteData  input  32  operand, already zero-extended for immediate forms
csrCommit  input  1  the access retires this cycle; writes apply only when this is 1
csrReadData  output  32  combinational pre-write value
csrIllegal  output  1  combinational illegal-access flag
retireCount  input  $clog2(MAX_RETIRE+1)  instructions retired this cycle
hpmEvent  input  NUM_EVENTS  per-cycle event pulses
overflowIrq  output  1  counter overflow interrupt (see Optional Feature)

Behaviour:
- Address map:
  - mcycle B00/B80; minstret B02/B82; mhpmcounterK B00+K / B80+K for K = 3..NUM_HPM+2.
  - mcountinhibit 320; mhpmeventK 320+K.
  - User shadows C00/C02/C03.. and C80/C82/C83.. are read-only.
- Low-half address returns counter[31:0]. High-half address returns counter[COUNTER_WIDTH-1:32], zero-extended.
- mcountinhibit:
  - Bit0 = CY, bit2 = IR, bit K = HPM K.
  - Bit1 and unimplemented bits are hardwired 0; writes to them are ignored.
- mhpmeventK[4:0] is an event index. Value 0 or a value > NUM_EVENTS means no event. Value v counts hpmEvent[v-1]. Bits [31:5] read 0.
- csrIllegal = csrValid and csrOp != 00, and either of:
  - the address is unmapped;
  - the address is a read-only shadow and a write is effective (RW always, or RS/RC with csrWriteIntent = 1).
- Write value:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
- A write is effective when csrValid & csrCommit & !csrIllegal & csrOp != 00 & (csrOp == RW | csrWriteIntent).
- Per-counter next state:
  - An effective write to a counter half wins. Next = old value with the written half replaced; bits above COUNTER_WIDTH are truncated. No increment that cycle for that counter.
  - Otherwise, if not inhibited: mcycle += 1; minstret += retireCount; HPM K += 1 when its selected event is high.
  - Arithmetic is full COUNTER_WIDTH with carry from the low to the high half. Wrap-around goes from all-ones to 0.
- A write to mcountinhibit takes effect from the next cycle. The increment in the write cycle uses the old inhibit value.
- csrReadData always reflects state before the current cycle's update. A read in the same cycle as a write returns the old value.
- Reset (rst_n = 0 at an edge) clears all counters, mcountinhibit, every mhpmevent and overflow state; overflowIrq = 0.
  - Reset asserted mid-operation discards any commit and increment in that cycle.
  - csrReadData and csrIllegal are combinational and carry no reset value.

Optional Feature:
- Macro: HPM_OVERFLOW_IRQ_EN.
- Enabled:
  - Each HPM counter has a sticky overflow flag, set when a non-write increment wraps to 0.
  - Flags are readable at a vendor CSR at 7C0 (bit K = HPM K).
  - Writes to 7C0 follow RW/RS/RC; a write in the same cycle as a set wins.
  - overflowIrq is registered: it equals the OR of the flags from the previous edge.
- Disabled: 7C0 is unmapped (illegal); overflowIrq is tied 0; no flag registers.

Test Plan:
- Reset, then 10 idle cycles, read B00 -> 0x0000000A; read B02 -> 0; csrIllegal = 0.
- RW B00 = 0xFFFFFFFF with commit, then 1 idle cycle, read B80 -> 0x00000001 and B00 -> 0x00000000 (carry into the high half).
- RW 320 = 0x5 (CY, IR) with commit, retireCount = 1 for 4 cycles -> mcycle and minstret frozen; bit1 reads 0.
- RW 323 = 2, pulse hpmEvent[1] 3 times and hpmEvent[0] 5 times -> mhpmcounter3 = 3.
- csrOp = RW to C00 -> csrIllegal = 1, no state change. csrOp = RS to C00 with csrWriteIntent = 0 -> csrIllegal = 0 and the read returns mcycle. Access to address 7FF -> csrIllegal = 1.
- With HPM_OVERFLOW_IRQ_EN: preload mhpmcounter3 to all-ones, pulse its event once -> counter = 0, flag bit3 = 1, overflowIrq = 1 one cycle later. RC 7C0 with 0x8 -> overflowIrq = 0 the cycle after.

Source files
------------

// File: rtl/csr_counter_bank.sv
// Machine counter bank: mcycle, minstret, mhpmcounter3.., mcountinhibit and mhpmevent CSRs.
// Define HPM_OVERFLOW_IRQ_EN to add sticky HPM overflow flags at 0x7C0 and a registered overflowIrq.
module csr_counter_bank #(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_HPM       = 4,
  parameter int NUM_EVENTS    = 8,
  parameter int MAX_RETIRE    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            csrValid,
  input  logic [11:0]                     csrAddr,
  input  logic [1:0]                      csrOp,
  input  logic                            csrWriteIntent,
  input  logic [31:0]                     csrWriteData,
  input  logic                            csrCommit,
  output logic [31:0]                     csrReadData,
  output logic                            csrIllegal,
  input  logic [$clog2(MAX_RETIRE+1)-1:0] retireCount,
  input  logic [NUM_EVENTS-1:0]           hpmEvent,
  output logic                            overflowIrq
);
  localparam int NCNT = NUM_HPM + 3;
  localparam int HI_W = COUNTER_WIDTH - 32;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef enum logic [2:0] {K_NONE, K_CNT, K_INH, K_EVT, K_OVF} kind_e;

  function automatic logic [31:0] hpm_mask();
    logic [31:0] m;
    m = '0;
    for (int k = 3; k < NCNT; k++) m[k] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] HPM_MASK  = hpm_mask();
  localparam logic [31:0] IMPL_MASK = HPM_MASK | 32'h0000_0005;

  function automatic logic ev_hit(input logic [4:0] sel, input logic [NUM_EVENTS-1:0] ev);
    logic hit;
    hit = 1'b0;
    for (int e = 0; e < NUM_EVENTS; e++) begin
      if ({27'd0, sel} == 32'(e + 1)) hit = ev[e];
    end
    return hit;
  endfunction

  // Index 0 is mcycle, 2 is minstret, 3.. are HPM counters; index 1 never changes from 0.
  function automatic logic [COUNTER_WIDTH-1:0] inc_amount(input int k,
                                                          input logic [$clog2(MAX_RETIRE+1)-1:0] rc,
                                                          input logic [NUM_EVENTS-1:0] ev,
                                                          input logic [4:0] sel);
    logic [COUNTER_WIDTH-1:0] amt;
    amt = '0;
    if (k == 0)      amt = COUNTER_WIDTH'(1);
    else if (k == 2) amt = COUNTER_WIDTH'(rc);
    else if (k >= 3) amt = COUNTER_WIDTH'(ev_hit(sel, ev));
    return amt;
  endfunction

  logic [COUNTER_WIDTH-1:0] cnt_q   [NCNT];
  logic [COUNTER_WIDTH-1:0] cnt_d   [NCNT];
  logic [4:0]               evsel_q [NCNT];
  logic [4:0]               evsel_d [NCNT];
  logic [31:0]              inh_q, inh_d;

  kind_e                    kind;
  logic [4:0]               idx;
  logic                     is_hi;
  logic                     is_shadow;
  logic [COUNTER_WIDTH-1:0] sel_cnt;
  logic [4:0]               sel_ev;
  logic [31:0]              old_val;
  logic [31:0]              wval;
  logic [31:0]              ovf_rd;
  logic [31:0]              ovf_set;
  logic                     wr_req;
  logic                     wr_eff;

  always_comb begin
    kind      = K_NONE;
    idx       = csrAddr[4:0];
    is_hi     = csrAddr[7];
    is_shadow = 1'b0;
    if ((csrAddr[11:8] == 4'hB || csrAddr[11:8] == 4'hC) && csrAddr[6:5] == 2'b00 && IMPL_MASK[idx]) begin
      kind      = K_CNT;
      is_shadow = (csrAddr[11:8] == 4'hC);
    end else if (csrAddr == 12'h320) begin
      kind = K_INH;
    end else if (csrAddr[11:5] == 7'h19 && HPM_MASK[idx]) begin
      kind = K_EVT;
    end
`ifdef HPM_OVERFLOW_IRQ_EN
    else if (csrAddr == 12'h7C0) begin
      kind = K_OVF;
    end
`endif
  end

  always_comb begin
    sel_cnt = '0;
    sel_ev  = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (idx == 5'(k)) begin
        sel_cnt = cnt_q[k];
        sel_ev  = evsel_q[k];
      end
    end
  end

  always_comb begin
    case (kind)
      K_CNT:   old_val = is_hi ? 32'(sel_cnt[COUNTER_WIDTH-1:32]) : sel_cnt[31:0];
      K_INH:   old_val = inh_q;
      K_EVT:   old_val = {27'd0, sel_ev};
      K_OVF:   old_val = ovf_rd;
      default: old_val = '0;
    endcase
  end

  assign csrReadData = old_val;
  assign wr_req      = (csrOp == OP_RW) || csrWriteIntent;
  assign csrIllegal  = csrValid && (csrOp != OP_NONE) &&
                       ((kind == K_NONE) || (is_shadow && wr_req));
  assign wr_eff      = csrValid && csrCommit && !csrIllegal && (csrOp != OP_NONE) && wr_req;

  always_comb begin
    case (csrOp)
      OP_RW:   wval = csrWriteData;
      OP_RS:   wval = old_val | csrWriteData;
      OP_RC:   wval = old_val & ~csrWriteData;
      default: wval = old_val;
    endcase
  end

  // A CSR write to a counter half replaces that half and suppresses the increment for the cycle.
  always_comb begin
    ovf_set = '0;
    for (int k = 0; k < NCNT; k++) begin
      cnt_d[k]   = cnt_q[k];
      evsel_d[k] = evsel_q[k];
      if (wr_eff && kind == K_CNT && idx == 5'(k)) begin
        if (is_hi) cnt_d[k] = {wval[HI_W-1:0], cnt_q[k][31:0]};
        else       cnt_d[k] = {cnt_q[k][COUNTER_WIDTH-1:32], wval};
      end else if (!inh_q[k]) begin
        cnt_d[k] = cnt_q[k] + inc_amount(k, retireCount, hpmEvent, evsel_q[k]);
        if (HPM_MASK[k] && ev_hit(evsel_q[k], hpmEvent) && (&cnt_q[k])) ovf_set[k] = 1'b1;
      end
      if (wr_eff && kind == K_EVT && idx == 5'(k)) evsel_d[k] = wval[4:0];
    end
    inh_d = (wr_eff && kind == K_INH) ? (wval & IMPL_MASK) : inh_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NCNT; k++) begin
        cnt_q[k]   <= '0;
        evsel_q[k] <= '0;
      end
      inh_q <= '0;
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        cnt_q[k]   <= cnt_d[k];
        evsel_q[k] <= evsel_d[k];
      end
      inh_q <= inh_d;
    end
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  logic [31:0] ovf_q, ovf_d;
  logic        irq_q;

  // A software write to the flag CSR overrides a flag being set in the same cycle.
  always_comb begin
    if (wr_eff && kind == K_OVF) ovf_d = wval & HPM_MASK;
    else                         ovf_d = (ovf_q | ovf_set) & HPM_MASK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= |ovf_q;
    end
  end

  assign ovf_rd      = ovf_q;
  assign overflowIrq = irq_q;
`else
  logic unused_ovf_set;
  assign unused_ovf_set = ^ovf_set;
  assign ovf_rd         = '0;
  assign overflowIrq    = 1'b0;
`endif

endmodule
